sseg_scan_mux_n: RTL
====================

# sseg_scan_mux_n

Parametrised time-multiplexed seven-segment driver, successor to the fixed 4-digit LED mux. It scans N_DIGITS common-select digits, one per slot. Each slot has an anti-ghosting dead time, a PWM brightness control, per-digit blanking and per-digit blinking. It sits between the per-digit hex_to_sseg encoders and the FMC LED-socket pins.

## Interface
- N_DIGITS, 4: number of digits scanned; ≥2.
- SLOT_W, 16: slot length is 2^SLOT_W clock cycles per digit.
- DEAD_CYCLES, 64: all-off cycles at the start of each slot; 1 ≤ DEAD_CYCLES < 2^SLOT_W.
- BRIGHT_W, 4: brightness code width; 1 ≤ BRIGHT_W ≤ SLOT_W.
- BLINK_FRAMES, 64: frames per blink half-period; ≥1.
- LDSEL_ACT, 1'b1: active level of o_ldsel bits.
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_in_n  in  [N_DIGITS-1:0] x 8  active-low segment pattern per digit, {dp,g..a}.
- i_blank  in  N_DIGITS  1 = digit forced dark.
- i_blink_en  in  N_DIGITS  1 = digit follows blink phase.
- i_bright  in  BRIGHT_W  brightness code; 0 = dimmest lit, all-ones = full.
- o_ldsel  out  N_DIGITS  digit select, one-hot active at LDSEL_ACT, or all inactive.
- o_sseg_n  out  8  active-low segments.
- o_frame_tick  out  1  one-cycle pulse at the start of each frame.
- o_digit_idx  out  $clog2(N_DIGITS)  digit currently owning the slot.

## Operation
- Slot counter cnt runs 0..2^SLOT_W-1 and wraps. At each wrap, digit index idx increments and wraps N_DIGITS-1 -> 0. One frame = N_DIGITS slots.
- The cycle with cnt==0 captures the slot data: i_in_n[idx], i_blank[idx] and i_blink_en[idx]. These hold for the whole slot, so mid-slot input changes are invisible.
- The cycle with cnt==0 and idx==0 also does three frame-start actions:
  - captures i_bright into the brightness register, so changes apply from the next frame only;
  - pulses o_frame_tick;
  - advances the frame counter.
- Frame counter: counts 0..BLINK_FRAMES-1. The blink phase toggles when it wraps. The blink phase is "on" out of reset.
- Brightness phase p = cnt[SLOT_W-1 -: BRIGHT_W].
- Per-cycle state, decoded from cnt:
  - DEAD: cnt < DEAD_CYCLES.
  - LIT: cnt ≥ DEAD_CYCLES, p ≤ bright_reg, captured blank = 0, and not (captured blink_en = 1 and blink phase off).
  - DARK: otherwise.
- Output mapping:
  - LIT: o_ldsel has only bit idx at LDSEL_ACT; o_sseg_n = captured pattern.
  - DEAD or DARK: all o_ldsel bits at ~LDSEL_ACT; o_sseg_n = 8'hFF.
- Select and segment outputs never change in the same cycle as a digit change. DEAD always separates them, so there is no ghosting.

## Timing
- All outputs are registered. The output for counter value c appears the cycle after cnt holds c. This fixed one-cycle latency applies equally to o_ldsel, o_sseg_n, o_frame_tick and o_digit_idx.
- Lit cycles per slot = min(2^SLOT_W, (bright+1)·2^(SLOT_W-BRIGHT_W)) − DEAD_CYCLES, clamped at ≥0.
- Reset (asynchronous, immediate):
  - o_ldsel all inactive, o_sseg_n = 8'hFF, o_frame_tick = 0, o_digit_idx = 0;
  - cnt = 0, idx = 0, frame counter = 0, blink phase on, bright_reg = 0, captured data = 8'hFF.
- The first cycle after reset release has cnt==0, idx==0. It captures digit-0 data and brightness. o_frame_tick pulses the following cycle.
- Reset asserted mid-LIT: outputs go idle in the same cycle, with no wait for a clock edge.
- Simultaneous slot wrap and frame wrap: index, frame counter and blink phase all update on the same edge. The new blink phase applies from the new frame's slot 0.

## Test plan
Common parameters: N_DIGITS=4, SLOT_W=4, DEAD_CYCLES=2, BRIGHT_W=2, BLINK_FRAMES=2, LDSEL_ACT=1.

- Reset: hold i_reset, then release.
  - During reset: o_ldsel=0000, o_sseg_n=FF, o_frame_tick=0.
  - First o_frame_tick occurs 2 cycles after release.
  - o_frame_tick repeats every 64 cycles.
- Scan order at full brightness: i_bright=3, i_in_n = {C0,F9,A4,B0}, digit 0 = C0.
  - Per 16-cycle slot, o_ldsel is 0001, 0010, 0100, 1000 in turn, with the matching pattern.
  - Each slot is lit for 14 consecutive cycles, preceded by 2 cycles of 0000/FF.
- Dimming: i_bright=0 gives 2 lit cycles per slot; i_bright=1 gives 6; i_bright=2 gives 10.
- Mid-frame brightness change: change i_bright 3 -> 0 during slot 2.
  - Slots 2 and 3 stay at 14 lit cycles.
  - The 2-cycle lit width starts at the next frame's slot 0.
- Blank and blink: set i_blank=0100 and i_blink_en=0010.
  - Digit 2 is never selected.
  - Digit 1 is lit in frames 0-1, dark in frames 2-3, and lit again in frame 4.
- Asynchronous reset mid-LIT, e.g. during digit 3: outputs become 0000/FF without a clock edge. After release, scanning restarts at digit 0 with the frame tick at +2 cycles.

Source files
------------

// File: rtl/sseg_scan_mux_n.sv
// sseg_scan_mux_n: time-multiplexed N-digit seven-segment driver
// with dead time, PWM dimming, per-digit blanking and blinking.
module sseg_scan_mux_n #(
  parameter int   N_DIGITS     = 4,
  parameter int   SLOT_W       = 16,
  parameter int   DEAD_CYCLES  = 64,
  parameter int   BRIGHT_W     = 4,
  parameter int   BLINK_FRAMES = 64,
  parameter logic LDSEL_ACT    = 1'b1,
  localparam int  IDX_W = $clog2(N_DIGITS),
  localparam int  FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [N_DIGITS-1:0][7:0] i_in_n,
  input  logic [N_DIGITS-1:0]      i_blank,
  input  logic [N_DIGITS-1:0]      i_blink_en,
  input  logic [BRIGHT_W-1:0]      i_bright,
  output logic [N_DIGITS-1:0]      o_ldsel,
  output logic [7:0]               o_sseg_n,
  output logic                     o_frame_tick,
  output logic [IDX_W-1:0]         o_digit_idx
);

  typedef enum logic [1:0] {
    ST_DEAD,
    ST_LIT,
    ST_DARK
  } slot_st_t;

  logic [SLOT_W-1:0]   cnt;
  logic [IDX_W-1:0]    idx;
  logic [FC_W-1:0]     fcnt;
  logic                blink_on;
  logic                blink_cur;
  logic [BRIGHT_W-1:0] bright_reg;
  logic [BRIGHT_W-1:0] phase;
  logic [7:0]          pat;
  logic                blank_c;
  logic                blink_c;
  logic                slot_start;
  logic                frame_start;
  logic                last_digit;
  logic                frame_wrap;
  slot_st_t            st;
  logic [N_DIGITS-1:0] sel_next;
  logic [7:0]          seg_next;

  assign slot_start  = (cnt == '0);
  assign frame_start = slot_start && (idx == '0);
  assign last_digit  = (idx == IDX_W'(N_DIGITS - 1));
  assign frame_wrap  = (fcnt == FC_W'(BLINK_FRAMES - 1));
  assign phase       = cnt[SLOT_W-1 -: BRIGHT_W];

  always_comb begin
    st = ST_DARK;
    if (cnt < SLOT_W'(DEAD_CYCLES))
      st = ST_DEAD;
    else if (phase <= bright_reg && !blank_c &&
             !(blink_c && !blink_cur))
      st = ST_LIT;
  end

  always_comb begin
    seg_next = 8'hFF;
    sel_next = {N_DIGITS{~LDSEL_ACT}};
    unique case (st)
      ST_LIT: begin
        seg_next      = pat;
        sel_next[idx] = LDSEL_ACT;
      end
      ST_DEAD, ST_DARK: ;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == '1)
        idx <= last_digit ? '0 : idx + 1'b1;
    end
  end

  // Blink phase is latched per frame, so a toggle shows from the next frame.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fcnt       <= '0;
      blink_on   <= 1'b1;
      blink_cur  <= 1'b1;
      bright_reg <= '0;
    end else if (frame_start) begin
      bright_reg <= i_bright;
      blink_cur  <= blink_on;
      if (frame_wrap) begin
        fcnt     <= '0;
        blink_on <= ~blink_on;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pat     <= 8'hFF;
      blank_c <= 1'b0;
      blink_c <= 1'b0;
    end else if (slot_start) begin
      pat     <= i_in_n[idx];
      blank_c <= i_blank[idx];
      blink_c <= i_blink_en[idx];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_ldsel      <= {N_DIGITS{~LDSEL_ACT}};
      o_sseg_n     <= 8'hFF;
      o_frame_tick <= 1'b0;
      o_digit_idx  <= '0;
    end else begin
      o_ldsel      <= sel_next;
      o_sseg_n     <= seg_next;
      o_frame_tick <= frame_start;
      o_digit_idx  <= idx;
    end
  end

endmodule
